// File: rtl/roic_word_align_if.sv
// Purpose : word stream from the lane deserializer into the aligner, and the
//           aligned word stream plus lock status out to the readout assembler.
// Latency : n/a (wiring only). Backpressure: none; din_valid is a strobe, no ready.
// Ports   : din/din_valid/train_en flow master->slave; dout/dout_valid/locked/
//           bit_offset/align_err flow slave->master.
interface roic_word_align_if #(
  parameter int WORD_SIZE = 24,
  parameter int OFF_W     = 5
);
  logic [WORD_SIZE-1:0] din;
  logic                 din_valid;
  logic                 train_en;
  logic [WORD_SIZE-1:0] dout;
  logic                 dout_valid;
  logic                 locked;
  logic [OFF_W-1:0]     bit_offset;
  logic                 align_err;

  // Upstream side: the deserializer / test driver.
  modport master (
    output din, din_valid, train_en,
    input  dout, dout_valid, locked, bit_offset, align_err
  );

  // Aligner side.
  modport slave (
    input  din, din_valid, train_en,
    output dout, dout_valid, locked, bit_offset, align_err
  );
endinterface

// File: rtl/roic_word_align.sv
// Purpose : finds the ROIC training word at any bit offset across two frame words,
//           locks to it and emits bit-aligned words plus lock status.
// Latency : 1 fclk from a din_valid word to dout/dout_valid while locked.
// Backpressure: none; every din_valid word is consumed, idle cycles hold all state.
// Ports   : fclk (only clock), rst (sync, active-high), bus (slave modport:
//           din/din_valid/train_en in; dout/dout_valid/locked/bit_offset/align_err out).
module roic_word_align #(
  parameter int                   WORD_SIZE    = 24,
  parameter logic [WORD_SIZE-1:0] SYNC_PATTERN = 24'hFFF000,
  parameter int                   LOCK_COUNT   = 4,
  parameter int                   LOSS_COUNT   = 4,
  parameter int                   OFF_W        = 5
) (
  input  logic               fclk,
  input  logic               rst,
  roic_word_align_if.slave   bus
);

  localparam int CNT_MAX = (LOCK_COUNT > LOSS_COUNT) ? LOCK_COUNT : LOSS_COUNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_C = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] LOSS_C = CNT_W'(LOSS_COUNT);
  localparam logic [CNT_W-1:0] SAT_C  = CNT_W'(CNT_MAX);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t               state;
  logic [WORD_SIZE-1:0] prev_word;
  logic [CNT_W-1:0]     match_cnt;
  logic [CNT_W-1:0]     miss_cnt;

  logic [WORD_SIZE-1:0] dout_q;
  logic                 dout_valid_q;
  logic                 locked_q;
  logic [OFF_W-1:0]     bit_offset_q;
  logic                 align_err_q;

  // Two-word window; MSB is the oldest bit received.
  logic [2*WORD_SIZE-1:0] win;
  logic [2*WORD_SIZE-1:0] win_sh;
  logic [WORD_SIZE-1:0]   cand;
  logic                   cand_ok;
  logic                   hit;
  logic [OFF_W-1:0]       hit_off;
  logic [CNT_W-1:0]       match_inc;
  logic [CNT_W-1:0]       miss_inc;

  assign win     = {prev_word, bus.din};
  // Shifting left by the offset brings candidate k into the top word.
  assign win_sh  = win << bit_offset_q;
  assign cand    = win_sh[2*WORD_SIZE-1 -: WORD_SIZE];
  assign cand_ok = (cand == SYNC_PATTERN);

  // Scan downwards so the last assignment, i.e. the lowest matching offset, wins.
  always_comb begin
    hit     = 1'b0;
    hit_off = '0;
    for (int k = WORD_SIZE - 1; k >= 0; k--) begin
      if (win[2*WORD_SIZE-1-k -: WORD_SIZE] == SYNC_PATTERN) begin
        hit     = 1'b1;
        hit_off = OFF_W'(k);
      end
    end
  end

  // Saturating increments: counters stick at their ceiling instead of wrapping.
  assign match_inc = (match_cnt == SAT_C) ? match_cnt : match_cnt + 1'b1;
  assign miss_inc  = (miss_cnt  == SAT_C) ? miss_cnt  : miss_cnt  + 1'b1;

  always_ff @(posedge fclk) begin
    if (rst) begin
      state        <= ST_SEARCH;
      prev_word    <= '0;
      match_cnt    <= '0;
      miss_cnt     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      bit_offset_q <= '0;
      align_err_q  <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      align_err_q  <= 1'b0;
      if (bus.din_valid) begin
        prev_word <= bus.din;
        case (state)
          ST_SEARCH: begin
            if (bus.train_en && hit) begin
              bit_offset_q <= hit_off;
              match_cnt    <= CNT_W'(1);
              if (LOCK_COUNT == 1) begin
                state    <= ST_LOCKED;
                locked_q <= 1'b1;
                miss_cnt <= '0;
              end else begin
                state <= ST_CONFIRM;
              end
            end
          end

          ST_CONFIRM: begin
            if (bus.train_en) begin
              if (cand_ok) begin
                match_cnt <= match_inc;
                if (match_inc >= LOCK_C) begin
                  state    <= ST_LOCKED;
                  locked_q <= 1'b1;
                  miss_cnt <= '0;
                end
              end else begin
                // Abandon this candidate quietly; it was never announced as locked.
                state     <= ST_SEARCH;
                match_cnt <= '0;
              end
            end
          end

          ST_LOCKED: begin
            // The word that triggers unlock is still delivered downstream.
            dout_q       <= cand;
            dout_valid_q <= 1'b1;
            if (bus.train_en) begin
              if (!cand_ok) begin
                if (miss_inc >= LOSS_C) begin
                  state       <= ST_SEARCH;
                  locked_q    <= 1'b0;
                  align_err_q <= 1'b1;
                  match_cnt   <= '0;
                  miss_cnt    <= '0;
                end else begin
                  miss_cnt <= miss_inc;
                end
              end else begin
                miss_cnt <= '0;
              end
            end
          end

          default: state <= ST_SEARCH;
        endcase
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.locked     = locked_q;
  assign bus.bit_offset = bit_offset_q;
  assign bus.align_err  = align_err_q;

endmodule

// File: tb/tb_roic_word_align.sv
module tb_roic_word_align;

  localparam int WS = 24;
  localparam int OW = 5;

  logic fclk;
  logic rst;

  roic_word_align_if #(.WORD_SIZE(WS), .OFF_W(OW)) bus_if ();

  roic_word_align #(
    .WORD_SIZE   (WS),
    .SYNC_PATTERN(24'hFFF000),
    .LOCK_COUNT  (4),
    .LOSS_COUNT  (4),
    .OFF_W       (OW)
  ) dut (
    .fclk(fclk),
    .rst (rst),
    .bus (bus_if)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  typedef struct {
    logic          rst;
    logic [WS-1:0] din;
    logic          v;
    logic          t;
    logic [WS-1:0] e_dout;
    logic          e_dv;
    logic          e_lk;
    logic [OW-1:0] e_off;
    logic          e_err;
  } vec_t;

  vec_t vq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic void add(input logic r, input logic [WS-1:0] d, input logic v,
                              input logic t, input logic [WS-1:0] ed, input logic edv,
                              input logic elk, input logic [OW-1:0] eoff, input logic eerr);
    vec_t x;
    x.rst = r; x.din = d; x.v = v; x.t = t;
    x.e_dout = ed; x.e_dv = edv; x.e_lk = elk; x.e_off = eoff; x.e_err = eerr;
    vq.push_back(x);
  endfunction

  task automatic check(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, sample just after the rising edge.
  task automatic drive(input logic r, input logic [WS-1:0] d, input logic v, input logic t);
    @(negedge fclk);
    rst              = r;
    bus_if.din       = d;
    bus_if.din_valid = v;
    bus_if.train_en  = t;
    @(posedge fclk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int err_seen;
    int err_at;

    rst              = 1'b1;
    bus_if.din       = '0;
    bus_if.din_valid = 1'b0;
    bus_if.train_en  = 1'b0;

    //   rst din        v  t   dout       dv lk off err
    add(1, 24'h000000, 0, 0, 24'h000000, 0, 0, 0,  0); // 0 reset
    // Aligned: first word only primes prev_word, then 4 matches at offset 0.
    add(0, 24'hFFF000, 1, 1, 24'h000000, 0, 0, 0,  0); // 1
    add(0, 24'hFFF000, 1, 1, 24'h000000, 0, 0, 0,  0); // 2 match 1
    add(0, 24'hFFF000, 1, 1, 24'h000000, 0, 0, 0,  0); // 3 match 2
    add(0, 24'hFFF000, 1, 1, 24'h000000, 0, 0, 0,  0); // 4 match 3
    add(0, 24'hFFF000, 1, 1, 24'h000000, 0, 1, 0,  0); // 5 match 4 -> locked
    // Gaps: offset 0 selects prev_word, so dout lags din by one word.
    add(0, 24'hABCDEF, 1, 0, 24'hFFF000, 1, 1, 0,  0); // 6
    add(0, 24'h111111, 0, 0, 24'hFFF000, 0, 1, 0,  0); // 7 gap, dout held
    add(0, 24'h222222, 1, 0, 24'hABCDEF, 1, 1, 0,  0); // 8
    add(0, 24'h333333, 0, 1, 24'hABCDEF, 0, 1, 0,  0); // 9 gap with train_en
    // Loss: four mismatching candidates.
    add(0, 24'h000000, 1, 1, 24'h222222, 1, 1, 0,  0); // 10 miss 1
    add(0, 24'h000000, 1, 1, 24'h000000, 1, 1, 0,  0); // 11 miss 2
    add(0, 24'h000000, 1, 1, 24'h000000, 1, 1, 0,  0); // 12 miss 3
    add(0, 24'h000000, 1, 1, 24'h000000, 1, 0, 0,  1); // 13 miss 4 -> unlock
    add(0, 24'h000000, 0, 1, 24'h000000, 0, 0, 0,  0); // 14 pulse gone
    // Re-lock, then 3 misses and a match must not unlock.
    add(0, 24'hFFF000, 1, 1, 24'h000000, 0, 0, 0,  0); // 15
    add(0, 24'hFFF000, 1, 1, 24'h000000, 0, 0, 0,  0); // 16
    add(0, 24'hFFF000, 1, 1, 24'h000000, 0, 0, 0,  0); // 17
    add(0, 24'hFFF000, 1, 1, 24'h000000, 0, 0, 0,  0); // 18
    add(0, 24'hFFF000, 1, 1, 24'h000000, 0, 1, 0,  0); // 19 locked
    add(0, 24'h000000, 1, 1, 24'hFFF000, 1, 1, 0,  0); // 20 match
    add(0, 24'h000000, 1, 1, 24'h000000, 1, 1, 0,  0); // 21 miss 1
    add(0, 24'h000000, 1, 1, 24'h000000, 1, 1, 0,  0); // 22 miss 2
    add(0, 24'hFFF000, 1, 1, 24'h000000, 1, 1, 0,  0); // 23 miss 3
    add(0, 24'hFFF000, 1, 1, 24'hFFF000, 1, 1, 0,  0); // 24 match clears
    add(0, 24'h000000, 1, 1, 24'hFFF000, 1, 1, 0,  0); // 25 still locked
    // Reset mid-lock with din_valid high: reset wins.
    add(1, 24'hABCDEF, 1, 1, 24'h000000, 0, 0, 0,  0); // 26
    // Confirm abort after 2 matches, then 4 fresh matches to lock.
    add(0, 24'h000000, 1, 1, 24'h000000, 0, 0, 0,  0); // 27
    add(0, 24'hFFF000, 1, 1, 24'h000000, 0, 0, 0,  0); // 28
    add(0, 24'hFFF000, 1, 1, 24'h000000, 0, 0, 0,  0); // 29 match 1
    add(0, 24'hABCDEF, 1, 1, 24'h000000, 0, 0, 0,  0); // 30 match 2
    add(0, 24'hFFF000, 1, 1, 24'h000000, 0, 0, 0,  0); // 31 abort
    add(0, 24'hFFF000, 1, 1, 24'h000000, 0, 0, 0,  0); // 32 fresh 1
    add(0, 24'hFFF000, 1, 1, 24'h000000, 0, 0, 0,  0); // 33 fresh 2
    add(0, 24'hFFF000, 1, 1, 24'h000000, 0, 0, 0,  0); // 34 fresh 3
    add(0, 24'hFFF000, 1, 1, 24'h000000, 0, 1, 0,  0); // 35 fresh 4 -> locked
    // Slip of 19 bits: pattern rotated left by 5 is 24'hFE001F.
    add(1, 24'h000000, 0, 0, 24'h000000, 0, 0, 0,  0); // 36
    add(0, 24'hFE001F, 1, 1, 24'h000000, 0, 0, 0,  0); // 37 no match vs zeros
    add(0, 24'hFE001F, 1, 1, 24'h000000, 0, 0, 19, 0); // 38
    add(0, 24'hFE001F, 1, 1, 24'h000000, 0, 0, 19, 0); // 39
    add(0, 24'hFE001F, 1, 1, 24'h000000, 0, 0, 19, 0); // 40
    add(0, 24'hFE001F, 1, 1, 24'h000000, 0, 1, 19, 0); // 41 locked
    // 24'h123456 rotated left by 5 is 24'h468AC2; first word straddles the boundary.
    add(0, 24'h468AC2, 1, 0, 24'hFA3456, 1, 1, 19, 0); // 42
    add(0, 24'h468AC2, 1, 0, 24'h123456, 1, 1, 19, 0); // 43

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].din, vq[i].v, vq[i].t);
      check("dout",       i, 32'(bus_if.dout),       32'(vq[i].e_dout));
      check("dout_valid", i, 32'(bus_if.dout_valid), 32'(vq[i].e_dv));
      check("locked",     i, 32'(bus_if.locked),     32'(vq[i].e_lk));
      check("bit_offset", i, 32'(bus_if.bit_offset), 32'(vq[i].e_off));
      check("align_err",  i, 32'(bus_if.align_err),  32'(vq[i].e_err));
    end

    // Loss at offset 19: exactly one align_err pulse, on the 4th bad word,
    // and the triggering word is still output.
    err_seen = 0;
    err_at   = -1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 24'h000000, 1'b1, 1'b1);
      if (i < 4) check("loss_dout_valid", i, 32'(bus_if.dout_valid), 32'd1);
      if (bus_if.align_err === 1'b1) begin
        err_seen++;
        err_at = i;
      end
    end
    check("loss_pulse_count", 0, 32'(err_seen), 32'd1);
    check("loss_pulse_at",    0, 32'(err_at),   32'd3);
    check("loss_locked",      0, 32'(bus_if.locked), 32'd0);
    check("loss_offset_held", 0, 32'(bus_if.bit_offset), 32'd19);

    // Idle cycles in the middle of confirmation must not disturb the count.
    drive(1'b0, 24'hFFF000, 1'b1, 1'b1);   // primes prev_word
    drive(1'b0, 24'hFFF000, 1'b1, 1'b1);   // match 1
    check("gap_offset", 0, 32'(bus_if.bit_offset), 32'd0);
    drive(1'b0, 24'hFFF000, 1'b1, 1'b1);   // match 2
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 24'h000000, 1'b0, 1'b1);
      check("gap_idle_locked", i, 32'(bus_if.locked), 32'd0);
    end
    drive(1'b0, 24'hFFF000, 1'b1, 1'b1);   // match 3
    check("gap_match3_locked", 0, 32'(bus_if.locked), 32'd0);
    drive(1'b0, 24'hFFF000, 1'b1, 1'b1);   // match 4
    check("gap_match4_locked", 0, 32'(bus_if.locked), 32'd1);
    check("gap_align_err",     0, 32'(bus_if.align_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
